// File: rtl/lc3_pkg.sv
// Shared LC-3 memory-interface definitions: access phases and fixed access timing.
package lc3_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PH0,
    PH1,
    PH2,
    DONE
  } mio_phase_t;

  localparam logic [15:0] IO_ADDR_DEFAULT   = 16'hFFFF;
  localparam int          MIO_ACCESS_CYCLES = 3;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs such as board switches.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: state elements use non-blocking assignments so every flop samples
  // the pre-edge value of its source, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// LC-3 memory/IO bridge: fixed three-phase access to async SRAM or to the
// memory-mapped switch/hex-display port.
module mem_io_bridge
  import lc3_pkg::*;
#(
  parameter logic [15:0] IO_ADDR = IO_ADDR_DEFAULT,
  parameter int          SRAM_AW = 20,
  parameter int          DATA_W  = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               MIO_EN,
  input  logic               R_W,
  input  logic [15:0]        MAR,
  input  logic [DATA_W-1:0]  MDR,
  output logic [DATA_W-1:0]  Data_to_CPU,
  output logic               Busy,
  input  logic [DATA_W-1:0]  Switches,
  output logic [DATA_W-1:0]  Hex_Data,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  input  logic [DATA_W-1:0]  SRAM_DQ_In,
  output logic [DATA_W-1:0]  SRAM_DQ_Out,
  output logic               SRAM_DQ_OE
);

  mio_phase_t        state, state_next;
  logic [15:0]       mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic              rw_q;
  logic              io_q;
  logic [DATA_W-1:0] switches_sync;
  logic              active;
  logic              sram_sel;
  logic              end_of_ph1;

  sync2 #(.W(DATA_W)) u_switch_sync (
    .clk   (Clk),
    .reset (Reset),
    .d     (Switches),
    .q     (switches_sync)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (MIO_EN) state_next = PH0;
      PH0:     state_next = MIO_EN ? PH1 : IDLE;
      PH1:     state_next = MIO_EN ? PH2 : IDLE;
      PH2:     state_next = MIO_EN ? DONE : IDLE;
      DONE:    if (!MIO_EN) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode only registered state, so they follow the phase exactly.
  assign active     = (state == PH0) || (state == PH1) || (state == PH2);
  assign sram_sel   = active && !io_q;
  assign end_of_ph1 = (state == PH1) && MIO_EN;

  always_comb begin
    SRAM_CE_N  = 1'b1;
    SRAM_UB_N  = 1'b1;
    SRAM_LB_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_WE_N  = 1'b1;
    SRAM_DQ_OE = 1'b0;
    if (sram_sel) begin
      SRAM_CE_N  = 1'b0;
      SRAM_UB_N  = 1'b0;
      SRAM_LB_N  = 1'b0;
      SRAM_OE_N  = rw_q;
      SRAM_WE_N  = !(rw_q && (state == PH1));
      SRAM_DQ_OE = rw_q;
    end
  end

  assign Busy        = active;
  assign SRAM_ADDR   = SRAM_AW'(mar_q);
  assign SRAM_DQ_Out = mdr_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      mar_q       <= '0;
      mdr_q       <= '0;
      rw_q        <= 1'b0;
      io_q        <= 1'b0;
      Data_to_CPU <= '0;
      Hex_Data    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && MIO_EN) begin
        mar_q <= MAR;
        mdr_q <= MDR;
        rw_q  <= R_W;
        io_q  <= (MAR == IO_ADDR);
      end
      if (end_of_ph1 && !rw_q) Data_to_CPU <= io_q ? switches_sync : SRAM_DQ_In;
      if (end_of_ph1 && rw_q && io_q) Hex_Data <= mdr_q;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Randomized scoreboard bench for mem_io_bridge with an emulated async SRAM.
module tb_mem_io_bridge;
  import lc3_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        MIO_EN = 1'b0;
  logic        R_W = 1'b0;
  logic [15:0] MAR = '0;
  logic [15:0] MDR = '0;
  logic [15:0] Switches = '0;
  logic [15:0] Data_to_CPU, Hex_Data, SRAM_DQ_In, SRAM_DQ_Out;
  logic [19:0] SRAM_ADDR;
  logic        Busy, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_OE;

  mem_io_bridge dut (
    .Clk(Clk), .Reset(Reset), .MIO_EN(MIO_EN), .R_W(R_W), .MAR(MAR), .MDR(MDR),
    .Data_to_CPU(Data_to_CPU), .Busy(Busy), .Switches(Switches), .Hex_Data(Hex_Data),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_DQ_In(SRAM_DQ_In), .SRAM_DQ_Out(SRAM_DQ_Out), .SRAM_DQ_OE(SRAM_DQ_OE)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] addr;
    int          busy;
    int          ce;
    int          oe;
    int          we;
    int          dqoe;
    bit          full_read;
    bit          check_mem;
    logic [15:0] exp_mem;
    logic [15:0] exp_dout;
    logic [15:0] exp_hex;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] ref_mem  [0:65535];
  logic [15:0] sram_mem [0:65535];
  logic [15:0] model_dout = '0;
  logic [15:0] model_hex = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Emulated async SRAM: read data appears while CE and OE are low, writes land on WE low.
  assign SRAM_DQ_In = (!SRAM_CE_N && !SRAM_OE_N) ? sram_mem[SRAM_ADDR[15:0]] : 16'h5A5A;

  always @(negedge Clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) begin
      check("we_needs_dq_oe", 32'(SRAM_DQ_OE), 32'd1);
      check("we_with_oe_high", 32'(SRAM_OE_N), 32'd1);
      sram_mem[SRAM_ADDR[15:0]] <= SRAM_DQ_Out;
    end
  end

  // Reference model: each access's expected observable effects, from the access rules.
  task automatic do_access(input bit rw, input logic [15:0] addr, input logic [15:0] data,
                           input int en_cycles, input int gap);
    exp_t e;
    bit   is_io = (addr == 16'hFFFF);
    bit   full  = (en_cycles >= MIO_ACCESS_CYCLES);
    int   ph    = full ? MIO_ACCESS_CYCLES : en_cycles;
    e.addr      = addr;
    e.busy      = ph;
    e.ce        = is_io ? 0 : ph;
    e.oe        = (!is_io && !rw) ? ph : 0;
    e.dqoe      = (!is_io && rw) ? ph : 0;
    e.we        = (!is_io && rw && ph >= 2) ? 1 : 0;
    if (e.we != 0) ref_mem[addr] = data;
    if (!rw && full) model_dout = is_io ? Switches : ref_mem[addr];
    if (rw && is_io && full) model_hex = data;
    e.full_read = !rw && full;
    e.check_mem = !is_io;
    e.exp_mem   = ref_mem[addr];
    e.exp_dout  = model_dout;
    e.exp_hex   = model_hex;
    exp_q.push_back(e);

    @(posedge Clk); #1;
    MIO_EN = 1'b1; R_W = rw; MAR = addr; MDR = data;
    for (int i = 0; i < en_cycles; i++) begin
      @(posedge Clk); #1;
      MAR = 16'($urandom); MDR = 16'($urandom); R_W = 1'($urandom);
    end
    if (en_cycles > MIO_ACCESS_CYCLES) begin
      check("held_state_done", 32'(dut.state), 32'(DONE));
      check("held_busy_low", 32'(Busy), 32'd0);
    end
    MIO_EN = 1'b0;
    repeat (gap) @(posedge Clk);
  endtask

  // Monitor: measures each Busy window and retires one scoreboard entry when it closes.
  int          n_busy, n_ce, n_bytes, n_oe, n_we, n_dqoe, addr_moves, idle_strobes = 0;
  logic [19:0] first_addr;
  logic [15:0] dout_ph2;
  bit          in_acc = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Busy) begin
        if (!in_acc) begin
          n_busy = 0; n_ce = 0; n_bytes = 0; n_oe = 0; n_we = 0; n_dqoe = 0;
          addr_moves = 0; first_addr = SRAM_ADDR;
        end
        in_acc = 1'b1;
        n_busy++;
        if (!SRAM_CE_N) n_ce++;
        if (!SRAM_UB_N && !SRAM_LB_N) n_bytes++;
        if (!SRAM_OE_N) n_oe++;
        if (!SRAM_WE_N) n_we++;
        if (SRAM_DQ_OE) n_dqoe++;
        if (SRAM_ADDR !== first_addr) addr_moves++;
        dout_ph2 = Data_to_CPU;
      end else begin
        if (!SRAM_CE_N || !SRAM_OE_N || !SRAM_WE_N || !SRAM_UB_N || !SRAM_LB_N || SRAM_DQ_OE)
          idle_strobes++;
        if (in_acc) begin
          in_acc = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_access", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("busy_cycles", 32'(n_busy), 32'(e.busy));
            check("ce_cycles", 32'(n_ce), 32'(e.ce));
            check("ub_lb_cycles", 32'(n_bytes), 32'(e.ce));
            check("oe_cycles", 32'(n_oe), 32'(e.oe));
            check("we_cycles", 32'(n_we), 32'(e.we));
            check("dq_oe_cycles", 32'(n_dqoe), 32'(e.dqoe));
            check("sram_addr", 32'(first_addr), 32'(e.addr));
            check("sram_addr_stable", 32'(addr_moves), 32'd0);
            check("data_to_cpu", 32'(Data_to_CPU), 32'(e.exp_dout));
            check("hex_data", 32'(Hex_Data), 32'(e.exp_hex));
            if (e.full_read) check("data_in_ph2", 32'(dout_ph2), 32'(e.exp_dout));
            if (e.check_mem) check("sram_contents", 32'(sram_mem[e.addr]), 32'(e.exp_mem));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [15:0] v;
    logic [15:0] addr;
    bit          rw;
    int          en;
    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      ref_mem[i]  = v;
      sram_mem[i] = v;
    end
    ref_mem[16'h3000]  = 16'hABCD;
    sram_mem[16'h3000] = 16'hABCD;

    repeat (3) @(posedge Clk);
    #1;
    check("rst_ce_n", 32'(SRAM_CE_N), 32'd1);
    check("rst_oe_n", 32'(SRAM_OE_N), 32'd1);
    check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    check("rst_ub_n", 32'(SRAM_UB_N), 32'd1);
    check("rst_lb_n", 32'(SRAM_LB_N), 32'd1);
    check("rst_dq_oe", 32'(SRAM_DQ_OE), 32'd0);
    check("rst_sram_addr", 32'(SRAM_ADDR), 32'd0);
    check("rst_dq_out", 32'(SRAM_DQ_Out), 32'd0);
    check("rst_data_to_cpu", 32'(Data_to_CPU), 32'd0);
    check("rst_hex", 32'(Hex_Data), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    Reset = 1'b0;

    do_access(1'b0, 16'h3000, 16'h0000, 3, 1);
    do_access(1'b1, 16'h3001, 16'h1234, 3, 2);
    Switches = 16'h00FF;
    do_access(1'b0, 16'hFFFF, 16'h0000, 3, 1);
    do_access(1'b1, 16'hFFFF, 16'hBEEF, 3, 1);
    do_access(1'b1, 16'h3002, 16'h7777, 1, 1);
    do_access(1'b0, 16'h3001, 16'h0000, 6, 1);
    do_access(1'b0, 16'h3000, 16'h0000, 3, 1);
    do_access(1'b1, 16'hFFFF, 16'hC0DE, 2, 1);
    do_access(1'b1, 16'hFFFE, 16'h4321, 3, 1);
    do_access(1'b0, 16'hFFFE, 16'h0000, 3, 1);

    // Reset lands during PH1 of an I/O write while the request is still up.
    exp_q.push_back('{addr: 16'hFFFF, busy: 2, ce: 0, oe: 0, we: 0, dqoe: 0, full_read: 1'b0,
                      check_mem: 1'b0, exp_mem: 16'h0000, exp_dout: 16'h0000, exp_hex: 16'h0000});
    model_dout = '0;
    model_hex  = '0;
    @(posedge Clk); #1;
    MIO_EN = 1'b1; R_W = 1'b1; MAR = 16'hFFFF; MDR = 16'h5555;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("midrst_ce_n", 32'(SRAM_CE_N), 32'd1);
    check("midrst_we_n", 32'(SRAM_WE_N), 32'd1);
    check("midrst_oe_n", 32'(SRAM_OE_N), 32'd1);
    check("midrst_hex", 32'(Hex_Data), 32'd0);
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    Reset = 1'b0;
    MIO_EN = 1'b0;
    @(posedge Clk);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0:       addr = 16'hFFFF;
        1:       addr = 16'hFFFE;
        default: addr = 16'h4000 + 16'($urandom_range(0, 7));
      endcase
      rw = 1'($urandom);
      case ($urandom_range(0, 9))
        0, 1:    en = $urandom_range(4, 6);
        2:       en = 1;
        3:       en = (rw && addr != 16'hFFFF) ? 1 : 2;
        default: en = 3;
      endcase
      Switches = 16'($urandom);
      do_access(rw, addr, 16'($urandom), en, $urandom_range(1, 3));
    end

    repeat (10) @(posedge Clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("idle_strobes", 32'(idle_strobes), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the LC-3 control unit and datapath. It consumes MIO_EN, R_W, MAR and MDR, and produces Data_to_CPU, which the datapath loads into MDR.
- Runs a fixed three-cycle access matching the control unit's nR1/nR2/R read and write states.
- Drives the external async SRAM strobes, or the memory-mapped I/O (switches in, hex display out) when the address hits IO_ADDR.

Parameters:
- IO_ADDR, 16'hFFFF, memory-mapped I/O address (switch read / hex write).
- SRAM_AW, 20, SRAM address width; MAR is zero-extended into it.
- DATA_W, 16, data width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- MIO_EN  in  1  memory access request; held high for exactly 3 cycles per access by the control unit.
- R_W  in  1  1 = write, 0 = read.
- MAR  in  16  access address.
- MDR  in  16  write data.
- Data_to_CPU  out  16  read data, valid in phase 2.
- Busy  out  1  high while an access is in phases 0..2.
- Switches  in  16  raw asynchronous board switches.
- Hex_Data  out  16  hex display register.
- SRAM_ADDR  out  SRAM_AW  SRAM address.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes.
- SRAM_DQ_In  in  16  SRAM data bus, read side.
- SRAM_DQ_Out  out  16  SRAM data bus, write side.
- SRAM_DQ_OE  out  1  tristate enable for the write side; the tristate buffer itself lives at top level.

Behaviour:
- **Reset values:**
  - phase FSM = IDLE.
  - All SRAM_*_N = 1, SRAM_DQ_OE = 0, SRAM_ADDR = 0, SRAM_DQ_Out = 0.
  - Data_to_CPU = 0, Hex_Data = 0, Busy = 0, switch synchronizer flops = 0.
  - Reset overrides everything, including an access in progress.
- **FSM states:** IDLE, PH0, PH1, PH2, DONE.
- **Transitions:**
  - IDLE -> PH0 when MIO_EN = 1. In that same cycle, latch MAR, MDR, R_W and is_io = (MAR == IO_ADDR).
  - PH0 -> PH1 -> PH2 unconditionally while MIO_EN = 1.
  - PH2 -> DONE if MIO_EN = 1, else -> IDLE.
  - DONE -> IDLE when MIO_EN = 0; otherwise stay in DONE. No new access starts until MIO_EN has been low for at least one cycle.
  - MIO_EN = 0 in PH0 or PH1 (abort): next state is IDLE, strobes deassert next cycle, no hex write, Data_to_CPU unchanged.
- **Latched fields:** address, data and R_W are latched at IDLE->PH0 only. Input changes during an access are ignored.
- **SRAM read** (is_io = 0, R_W = 0):
  - CE_N, OE_N, UB_N, LB_N low in PH0..PH2.
  - SRAM_DQ_In registered into Data_to_CPU at the end of PH1, so it is stable throughout PH2 when the control unit asserts LD_MDR.
- **SRAM write** (is_io = 0, R_W = 1):
  - CE_N, UB_N, LB_N low in PH0..PH2.
  - SRAM_DQ_OE high in PH0..PH2, with SRAM_DQ_Out = latched MDR.
  - WE_N low in PH1 only, giving one cycle of address/data setup and hold. OE_N stays high.
- **I/O read** (is_io = 1, R_W = 0):
  - No SRAM strobes.
  - Data_to_CPU = synchronized switch value, registered at the end of PH1.
- **I/O write** (is_io = 1, R_W = 1):
  - No SRAM strobes.
  - Hex_Data <= latched MDR at the end of PH1, exactly once per access.
- **SRAM outputs:** SRAM_ADDR = {zeros, latched MAR} during PH0..PH2, and holds its last value otherwise.
- **Busy** = 1 in PH0..PH2 only.
- **Data_to_CPU** holds its value until the next completed read. Write accesses never change it.
- **Switch synchronizer:** Switches pass through two flops before use; I/O read latency from a switch change is at most 2 cycles.
- **Address boundaries:** address 16'hFFFE and all other non-IO addresses go to SRAM; no other decode exists.

Decomposition:
- Shared package (lc3_pkg) holds:
  - enum mio_phase_t {IDLE, PH0, PH1, PH2, DONE};
  - localparam IO_ADDR_DEFAULT = 16'hFFFF;
  - localparam MIO_ACCESS_CYCLES = 3.
- One sub-module: sync2 (parameterized-width two-flop synchronizer) for Switches.

Test Plan:
- SRAM read:
  - Stimulus: preload model M[16'h3000] = 16'hABCD; MIO_EN = 1 for 3 cycles, R_W = 0, MAR = 16'h3000.
  - Required: OE_N/CE_N low in PH0..PH2; Data_to_CPU = 16'hABCD in PH2; WE_N never low; SRAM_ADDR = 20'h03000.
- SRAM write:
  - Stimulus: MAR = 16'h3001, MDR = 16'h1234, R_W = 1, MIO_EN = 1 for 3 cycles.
  - Required: WE_N low for exactly 1 cycle (PH1); DQ_OE high in PH0..PH2; model M[16'h3001] = 16'h1234; Data_to_CPU unchanged.
- I/O:
  - Stimulus: Switches = 16'h00FF, then an I/O read at 16'hFFFF; then an I/O write with MDR = 16'hBEEF.
  - Required: no SRAM strobe asserted in either access; read gives Data_to_CPU = 16'h00FF; write gives Hex_Data = 16'hBEEF after PH1.
- Abort:
  - Stimulus: write to 16'h3002 with MIO_EN dropped after 1 cycle (PH0).
  - Required: WE_N never low; FSM back in IDLE; memory unchanged; Busy = 0 the next cycle.
- Held request:
  - Stimulus: MIO_EN held high for 6 cycles on a read.
  - Required: exactly one access (strobes active 3 cycles); FSM remains in DONE until MIO_EN drops, then a new 3-cycle read works.
- Reset mid-access:
  - Stimulus: Reset asserted in PH1 of a write to 16'hFFFF.
  - Required: all strobes high, Hex_Data = 0, FSM in IDLE on the next edge.
